// File: rtl/rt_mem_pkg.sv
// Shared triangle-memory definitions: loader state encoding, beat width and
// the terminator convention used by both the loader and the triangle memory.
package rt_mem_pkg;

  localparam int BEAT_W = 128;

  localparam logic [BEAT_W-1:0] TERMINATOR = '0;

  typedef enum logic [3:0] {
    IDLE,
    IDX_LOAD,
    IDX_WAIT,
    IDX_TERM,
    IDX_TERM_WAIT,
    VTX_LOAD,
    VTX_WAIT,
    VTX_TERM,
    FINISH
  } state_t;

  // A beat whose low word is zero closes a phase, so real data must never carry one.
  function automatic logic beat_is_terminator(input logic [BEAT_W-1:0] beat);
    return beat[31:0] == 32'h0;
  endfunction

endpackage

// File: rtl/triangle_loader_if.sv
// Source-stream and triangle-memory write bus seen by the loader.
interface triangle_loader_if;
  import rt_mem_pkg::*;

  logic              src_valid;
  logic [BEAT_W-1:0] src_data;
  logic              src_ready;
  logic              we_MC;
  logic [BEAT_W-1:0] data_MC;
  logic              rdy_MC;

  modport master (
    input  src_valid, src_data, rdy_MC,
    output src_ready, we_MC, data_MC
  );

  modport slave (
    output src_valid, src_data, rdy_MC,
    input  src_ready, we_MC, data_MC
  );
endinterface

// File: rtl/triangle_loader_wait_timer.sv
// Loadable down-counter; expired is high once the count has run out.
module wait_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);
endmodule

// File: rtl/triangle_loader.sv
// Streams index beats, an index terminator, vertex beats and a vertex
// terminator from the source stream into the triangle memory.
module triangle_loader
  import rt_mem_pkg::*;
#(
  parameter int NUM_TRIANGLE = 512,
  parameter int CNT_W        = 12,
  parameter int TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_index_beats,
  input  logic [CNT_W-1:0]   num_vertex_beats,
  triangle_loader_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(3 * NUM_TRIANGLE);

  state_t           state;
  logic [CNT_W-1:0] idx_cnt;
  logic [CNT_W-1:0] vtx_cnt;
  logic             src_fire;
  logic             src_bad;
  logic             timer_load;
  logic             timer_expired;

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] n);
    return (n > MAX_BEATS) ? MAX_BEATS : n;
  endfunction

  // Vertex beats are acked in their strobe cycle, so the next beat may be
  // accepted while the previous strobe is still on the bus.
  assign bus.src_ready = (state == IDX_LOAD) ||
                         ((state == VTX_LOAD) && (vtx_cnt != '0) &&
                          (!bus.we_MC || bus.rdy_MC));
  assign src_fire   = bus.src_valid && bus.src_ready;
  assign src_bad    = beat_is_terminator(bus.src_data);
  assign timer_load = (src_fire && !src_bad) || (state == IDX_TERM) || (state == VTX_TERM);

  wait_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (TW'(TIMEOUT - 1)),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx_cnt     <= '0;
      vtx_cnt     <= '0;
      bus.we_MC   <= 1'b0;
      bus.data_MC <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      bus.we_MC <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx_cnt <= clamp(num_index_beats);
            vtx_cnt <= clamp(num_vertex_beats);
            error   <= 1'b0;
            busy    <= 1'b1;
            state   <= (num_index_beats == '0) ? IDX_TERM : IDX_LOAD;
          end
        end
        IDX_LOAD: begin
          if (src_fire) begin
            if (src_bad) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bus.data_MC <= bus.src_data;
              bus.we_MC   <= 1'b1;
              idx_cnt     <= idx_cnt - 1'b1;
              state       <= IDX_WAIT;
            end
          end
        end
        IDX_WAIT: begin
          if (bus.rdy_MC) begin
            state <= (idx_cnt != '0) ? IDX_LOAD : IDX_TERM;
          end else if (timer_expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        IDX_TERM: begin
          bus.data_MC <= TERMINATOR;
          bus.we_MC   <= 1'b1;
          state       <= IDX_TERM_WAIT;
        end
        IDX_TERM_WAIT: begin
          if (bus.rdy_MC) begin
            state <= (vtx_cnt != '0) ? VTX_LOAD : VTX_TERM;
          end else if (timer_expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        VTX_LOAD: begin
          if (bus.we_MC && !bus.rdy_MC) begin
            state <= VTX_WAIT;
          end else if (src_fire) begin
            if (src_bad) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bus.data_MC <= bus.src_data;
              bus.we_MC   <= 1'b1;
              vtx_cnt     <= vtx_cnt - 1'b1;
            end
          end else if (vtx_cnt == '0) begin
            state <= VTX_TERM;
          end
        end
        VTX_WAIT: begin
          if (bus.rdy_MC) begin
            state <= (vtx_cnt != '0) ? VTX_LOAD : VTX_TERM;
          end else if (timer_expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        VTX_TERM: begin
          bus.data_MC <= TERMINATOR;
          bus.we_MC   <= 1'b1;
          done        <= 1'b1;
          state       <= FINISH;
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/triangle_loader.md
# triangle_loader

Memory-controller-side transmitter that streams a scene's triangle data into the triangle memory over the `we_MC`/`data_MC`/`rdy_MC` write interface. It pulls 128-bit beats from an upstream source stream (DMA/host FIFO) and emits them in a fixed two-phase sequence:
- Index beats (four 32-bit index words each), closed by an all-zero terminator beat.
- Vertex beats (x, y, z, flag), closed by an all-zero terminator beat.

It sits between the host DMA path and the triangle memory, runs once per scene load, and reports completion or a protocol error to the control unit.

## Interface
- `NUM_TRIANGLE`, default 512: triangle capacity; bounds the beat counts.
- `CNT_W`, default 12: beat counter width; covers 3*`NUM_TRIANGLE` vertex beats.
- `TIMEOUT`, default 64: maximum number of cycles to wait for `rdy_MC` after a beat.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a load. Ignored while `busy`.
- `num_index_beats` in `CNT_W`: index beats to send; sampled on `start`.
- `num_vertex_beats` in `CNT_W`: vertex beats to send; sampled on `start`.
- `src_valid` in 1: source beat available.
- `src_data` in 128: source beat.
- `src_ready` out 1: loader accepts the source beat this cycle.
- `we_MC` out 1: one-cycle write strobe per beat.
- `data_MC` out 128: beat data, registered.
- `rdy_MC` in 1: triangle memory has consumed the outstanding beat.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse when a load completes successfully.
- `error` out 1: sticky error flag; cleared by the next accepted `start`.

## Operation
States: IDLE, IDX_LOAD, IDX_WAIT, IDX_TERM, IDX_TERM_WAIT, VTX_LOAD, VTX_WAIT, VTX_TERM, FINISH.

- **IDLE**
  - On `start`: latch both counts, clear `error`, go to IDX_LOAD.
  - If `num_index_beats` is 0, go to IDX_TERM instead.
- **IDX_LOAD**
  - `src_ready` = 1.
  - On source handshake: `data_MC` <= `src_data`, `we_MC` <= 1 for one cycle, decrement the index count, go to IDX_WAIT.
  - If `src_data[31:0]` == 0: set `error`, go to IDLE, and do not assert `we_MC`. A zero low word would be taken as the terminator.
- **IDX_WAIT**
  - `src_ready` = 0, `we_MC` = 0.
  - On `rdy_MC`: go to IDX_LOAD if the count is nonzero, else IDX_TERM.
- **IDX_TERM**
  - `data_MC` <= 0, `we_MC` pulses, go to IDX_TERM_WAIT.
- **IDX_TERM_WAIT**
  - On `rdy_MC`: go to VTX_LOAD, or to VTX_TERM if `num_vertex_beats` is 0.
- **VTX_LOAD**
  - `src_ready` = 1 when no beat is outstanding, or when the outstanding beat sees `rdy_MC` this cycle (back-to-back streaming).
  - On handshake: load `data_MC`, pulse `we_MC`, decrement the vertex count.
  - A zero flag (`src_data[31:0]` == 0) is an error, same as in IDX_LOAD.
  - If `rdy_MC` is absent in the strobe cycle: go to VTX_WAIT with `we_MC` low. `we_MC` is never held high across cycles, because a held strobe double-writes.
  - When the last vertex beat's `rdy_MC` arrives: go to VTX_TERM.
- **VTX_WAIT**
  - On `rdy_MC`: go to VTX_LOAD, or to VTX_TERM if the count is 0.
- **VTX_TERM**
  - `data_MC` <= 0, pulse `we_MC`, go to FINISH.
  - Do not wait for `rdy_MC`: the memory does not acknowledge the final terminator.
- **FINISH**
  - Pulse `done`, go to IDLE.

Timeout:
- A wait counter resets on every `we_MC` pulse.
- In any *_WAIT state, reaching `TIMEOUT` cycles without `rdy_MC` sets `error` and returns to IDLE with no `done`.

Boundary conditions:
- `rdy_MC` seen outside an outstanding beat is ignored.
- `src_valid` is ignored outside the LOAD states.
- Reset mid-load returns to IDLE immediately, with no terminator sent.

## Timing
- Reset values: `we_MC` 0, `data_MC` 0, `src_ready` 0, `busy` 0, `done` 0, `error` 0. Counters and state reset to 0/IDLE.
- `busy` is registered: high from the cycle after the accepted `start` through FINISH.
- `we_MC` and `data_MC` are registered: the strobe appears the cycle after the source handshake.
- Index beat: the memory returns `rdy_MC` 4 cycles after `we_MC`, so the minimum index throughput is 1 beat per 6 cycles.
- Index terminator: `rdy_MC` arrives 1 cycle after its strobe.
- Vertex beat: `rdy_MC` is same-cycle with `we_MC`, so the loader streams 1 beat per cycle while `src_valid` stays high.

## Structure
- Shared package `rt_mem_pkg`:
  - State enum.
  - `BEAT_W` = 128.
  - The terminator constant (128'h0).
  - A `beat_is_terminator` function (low word == 0), also used by the triangle memory.
- Optional sub-module `wait_timer` (loadable down-counter with expire flag).
- All other logic is one FSM module.

## Test plan
- 2 index beats + 3 vertex beats with an ideal memory model:
  - `data_MC` sequence is idx0, idx1, 0, v0, v1, v2, 0.
  - `done` pulses once and `error` stays 0.
- Vertex streaming with `src_valid` held high and same-cycle `rdy_MC`: three consecutive `we_MC` cycles carrying v0..v2.
- `num_index_beats`=0, `num_vertex_beats`=0: `data_MC` is exactly two zero beats, then `done`.
- Index beat with `src_data[31:0]`=0: no `we_MC`, `error`=1, back to IDLE with `busy`=0, no `done`.
- `rdy_MC` withheld after a beat: `error` rises after 64 cycles, no `done`.
- Reset asserted in VTX_WAIT: all outputs 0 immediately. A new `start` then replays the full sequence correctly.
